// File: rtl/uart_alu_pkg.sv
// Shared opcodes, header length and controller state encoding for the UART ALU.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;

  localparam int unsigned HDR_LEN = 4;

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    RSVD,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    RESPOND
  } ctrl_state_t;

endpackage

// File: rtl/uart_alu_ctrl.sv
// Packet state machine, 32-bit accumulator and 4-entry response FIFO.
// Define UART_ALU_MUL_EN to accept the mul32 opcode.
module uart_alu_ctrl
  import uart_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_rx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  input  logic       i_tx_busy,
  output logic       o_busy
);

  ctrl_state_t r_state;
  logic [7:0]  r_op;
  logic [7:0]  r_len_lo;
  logic [15:0] r_remain;
  logic [31:0] r_acc;
  logic [31:0] r_word;
  logic [1:0]  r_bidx;
  logic [2:0]  r_resp_cnt;
  logic [7:0]  r_mem [4];
  logic [1:0]  r_wp;
  logic [1:0]  r_rp;
  logic [2:0]  r_count;

  logic        w_is_echo, w_is_add, w_is_mul, w_is_arith;
  logic        w_full, w_push, w_pop, w_resp_done;
  logic [7:0]  w_push_data;
  logic [15:0] w_len;
  logic [31:0] w_word, w_acc_next;

  assign o_rx_ready = 1'b1;
  assign o_busy     = (r_state != IDLE);
  assign w_is_echo  = (r_op == OP_ECHO);
  assign w_is_add   = (r_op == OP_ADD);
`ifdef UART_ALU_MUL_EN
  assign w_is_mul   = (r_op == OP_MUL);
  assign w_acc_next = w_is_mul ? r_acc * w_word : r_acc + w_word;
`else
  assign w_is_mul   = 1'b0;
  assign w_acc_next = r_acc + w_word;
`endif
  assign w_is_arith  = w_is_add || w_is_mul;
  assign w_len       = {i_rx_data, r_len_lo};
  assign w_word      = {i_rx_data, r_word[31:8]};
  assign w_full      = (r_count == 3'd4);
  assign o_tx_valid  = (r_count != 3'd0);
  assign o_tx_data   = r_mem[r_rp];
  assign w_pop       = o_tx_valid && i_tx_ready;
  assign w_resp_done = !w_is_arith || (r_resp_cnt == 3'd4);

  always_comb begin
    w_push      = 1'b0;
    w_push_data = i_rx_data;
    if (r_state == PAYLOAD && i_rx_valid && w_is_echo) begin
      w_push = !w_full;
    end else if (r_state == RESPOND && !w_resp_done) begin
      w_push      = !w_full;
      w_push_data = r_acc[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_len_lo   <= '0;
      r_remain   <= '0;
      r_acc      <= '0;
      r_word     <= '0;
      r_bidx     <= '0;
      r_resp_cnt <= '0;
    end else begin
      case (r_state)
        IDLE:   if (i_rx_valid) begin r_op <= i_rx_data; r_state <= OPCODE; end
        OPCODE: if (i_rx_valid) r_state <= RSVD;
        RSVD:   if (i_rx_valid) begin r_len_lo <= i_rx_data; r_state <= LEN_LO; end
        LEN_LO: if (i_rx_valid) begin
          r_remain <= (w_len < 16'(HDR_LEN)) ? '0 : w_len - 16'(HDR_LEN);
          r_state  <= LEN_HI;
        end
        LEN_HI: begin
          r_acc      <= w_is_mul ? 32'd1 : 32'd0;
          r_bidx     <= '0;
          r_resp_cnt <= '0;
          r_state    <= (r_remain == 16'd0) ? RESPOND : PAYLOAD;
        end
        PAYLOAD: if (i_rx_valid) begin
          r_remain <= r_remain - 16'd1;
          r_word   <= w_word;
          r_bidx   <= r_bidx + 2'd1;
          if (r_bidx == 2'd3 && w_is_arith) r_acc <= w_acc_next;
          if (r_remain == 16'd1) r_state <= RESPOND;
        end
        RESPOND: begin
          // Result bytes leave LSB first by shifting the accumulator down.
          if (w_push) begin
            r_acc      <= {8'h00, r_acc[31:8]};
            r_resp_cnt <= r_resp_cnt + 3'd1;
          end
          if (w_resp_done && r_count == 3'd0 && !i_tx_busy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, valid/ready byte output.
module uart_rx #(
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid
);

  localparam int CW = $clog2(PRESCALE + 1);
  localparam logic [CW-1:0] FULL = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] HALF = CW'(PRESCALE / 2 - 1);

  logic [1:0]    r_sync;
  logic          r_active;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_rx;
  logic [CW-1:0] w_lim;

  assign w_rx  = r_sync[1];
  // Start bit waits half a period to land mid-bit; later bits wait a full period.
  assign w_lim = (r_bit == 4'd0) ? HALF : FULL;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= 2'b11;
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx_i};
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (!r_active) begin
        r_cnt <= '0;
        r_bit <= '0;
        if (!w_rx) r_active <= 1'b1;
      end else if (r_cnt != w_lim) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
        if (r_bit == 4'd0) begin
          if (w_rx) r_active <= 1'b0;
          else      r_bit    <= 4'd1;
        end else if (r_bit <= 4'd8) begin
          r_shift <= {w_rx, r_shift[7:1]};
          r_bit   <= r_bit + 4'd1;
        end else begin
          r_active <= 1'b0;
          if (w_rx) begin
            o_data  <= r_shift;
            o_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready input; accepts the next byte in the last stop-bit cycle.
module uart_tx #(
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_busy,
  output logic       tx_o
);

  localparam int CW = $clog2(PRESCALE + 1);
  localparam logic [CW-1:0] FULL = CW'(PRESCALE - 1);

  logic          r_busy;
  logic          r_tx;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;
  logic          w_last;

  assign w_last  = r_busy && (r_cnt == FULL) && (r_bit == 4'd9);
  assign o_ready = !r_busy || w_last;
  assign o_busy  = r_busy;
  assign tx_o    = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '1;
    end else if (i_valid && o_ready) begin
      r_busy  <= 1'b1;
      r_tx    <= 1'b0;
      r_shift <= {1'b1, i_data};
      r_cnt   <= '0;
      r_bit   <= '0;
    end else if (r_busy) begin
      if (r_cnt != FULL) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
        end else begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/icebreaker_uart_alu.sv
// UART packet ALU top: echo / add32 (and mul32 when UART_ALU_MUL_EN is defined) over 8N1 serial.
module icebreaker_uart_alu #(
  parameter int CLK_FREQ_HZ = 31500000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic tx_o,
  output logic busy_o
);

  localparam int PRESCALE = CLK_FREQ_HZ / BAUD_RATE;

  logic [7:0] w_rx_data, w_tx_data;
  logic       w_rx_valid, w_rx_ready, w_tx_valid, w_tx_ready, w_tx_busy;

  uart_rx #(.PRESCALE(PRESCALE)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx_i    (rx_i),
    .i_ready (w_rx_ready),
    .o_data  (w_rx_data),
    .o_valid (w_rx_valid)
  );

  uart_alu_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_rx_data  (w_rx_data),
    .i_rx_valid (w_rx_valid),
    .o_rx_ready (w_rx_ready),
    .o_tx_data  (w_tx_data),
    .o_tx_valid (w_tx_valid),
    .i_tx_ready (w_tx_ready),
    .i_tx_busy  (w_tx_busy),
    .o_busy     (busy_o)
  );

  uart_tx #(.PRESCALE(PRESCALE)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_tx_data),
    .i_valid (w_tx_valid),
    .o_ready (w_tx_ready),
    .o_busy  (w_tx_busy),
    .tx_o    (tx_o)
  );

endmodule

// File: tb/tb_icebreaker_uart_alu.sv
// Directed scoreboard bench for icebreaker_uart_alu (mul expectations follow UART_ALU_MUL_EN).
module tb_icebreaker_uart_alu;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_i = 1'b1;
  logic tx_o, busy_o;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] pkt [$];
  logic mon_active = 1'b0;

  always #5 clk = ~clk;

  icebreaker_uart_alu #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rx_i),
    .tx_o   (tx_o),
    .busy_o (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_cycles);
    rx_i = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BIT) @(posedge clk);
    end
    rx_i = 1'b1;
    repeat (stop_cycles) @(posedge clk);
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i], BIT);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy_o && !mon_active) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++;
    assert (ok) else begin
      n_bad++;
      $error("FAIL %s_drain got=%0d pending exp=0", tag, exp_q.size());
    end
    repeat (3 * BIT) @(posedge clk); #1;
    check({tag, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  // Serial monitor: decodes tx_o frames and pops the scoreboard.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_o);
      if (rst) continue;
      mon_active = 1'b1;
      repeat (BIT / 2) @(posedge clk); #1;
      check("start_bit", {31'd0, tx_o}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(posedge clk); #1;
        b[i] = tx_o;
      end
      repeat (BIT) @(posedge clk); #1;
      check("stop_bit", {31'd0, tx_o}, 32'd1);
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $error("FAIL unexpected_byte got=%0h exp=none", b);
      end else begin
        check("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
      end
      mon_active = 1'b0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_bad;
    repeat (5) @(posedge clk); #1;
    check("reset_tx", {31'd0, tx_o}, 32'd1);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b0;
    repeat (2 * BIT) @(posedge clk);

    pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    send_pkt();
    wait_done("echo");

    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    exp_q.push_back(8'h03); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    send_pkt();
    wait_done("add");

    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    send_pkt();
    wait_done("add_wrap");

    pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
`ifdef UART_ALU_MUL_EN
    exp_q.push_back(8'h0F); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
`endif
    send_pkt();
    wait_done("mul");

    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_pkt();
    wait_done("unknown");
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h42};
    exp_q.push_back(8'h42);
    send_pkt();
    wait_done("echo_after_unknown");

    // Length below header size: add with no operands answers zero.
    pkt = '{8'hAD, 8'h00, 8'h02, 8'h00};
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    send_pkt();
    wait_done("short_len");

    pkt = '{8'hAD, 8'h00, 8'h0A, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h09};
    exp_q.push_back(8'h05); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    send_pkt();
    wait_done("partial_word");

    // Reset lands inside the stop bit of the first echo payload byte.
    pkt = '{8'hEC, 8'h00, 8'h08, 8'h00};
    send_pkt();
    send_byte(8'h11, 3);
    rst = 1'b1;
    seen_bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) seen_bad = 1'b1;
    end
    check("reset_hold", {31'd0, seen_bad}, 32'd0);
    rst = 1'b0;
    seen_bad = 1'b0;
    for (int i = 0; i < 4 * BIT; i++) begin
      @(posedge clk); #1;
      if (tx_o !== 1'b1) seen_bad = 1'b1;
    end
    check("post_reset_quiet", {31'd0, seen_bad}, 32'd0);
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    exp_q.push_back(8'h5A);
    send_pkt();
    wait_done("echo_after_reset");

    repeat (20 * BIT) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
